prbs_checker: RTL and testbench

Receive-side PRBS checker for the bit error ratio tester. It consumes the serial stream returned from the channel, self-synchronises a local PRBS-7 or PRBS-13 reference, and counts checked bits and bit errors once lock is achieved. It is the far-end counterpart of the PRBS transmit path and closes the loop for on-board BER measurement.

---
 rtl/prbs_checker_pkg.sv | 31 +++
 rtl/prbs_predict.sv | 23 ++
 rtl/prbs_checker.sv | 167 ++++++++++++++++
 tb/tb_prbs_checker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_checker_pkg.sv
// Shared PRBS definitions: checker state encoding, polynomial taps, seed lengths.
package prbs_checker_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int unsigned SREG_W     = 13;
    localparam int unsigned FILL_W     = 4;

    localparam int unsigned PRBS7_LEN  = 7;
    localparam int unsigned PRBS13_LEN = 13;

    // x^7 + x^6 + 1
    localparam int unsigned PRBS7_TAP_A = 6;
    localparam int unsigned PRBS7_TAP_B = 5;

    // x^13 + x^12 + x^11 + x^8 + 1
    localparam int unsigned PRBS13_TAP_A = 12;
    localparam int unsigned PRBS13_TAP_B = 11;
    localparam int unsigned PRBS13_TAP_C = 10;
    localparam int unsigned PRBS13_TAP_D = 7;

    // Number of bits needed to seed the reference for the selected pattern.
    function automatic logic [FILL_W-1:0] seed_len(input logic mode);
        return mode ? FILL_W'(PRBS13_LEN) : FILL_W'(PRBS7_LEN);
    endfunction

endpackage

// File: rtl/prbs_predict.sv
// Next-bit generator for PRBS-7 / PRBS-13 from the reference shift register.
module prbs_predict
    import prbs_checker_pkg::*;
(
    input  logic [SREG_W-1:0] sreg,
    input  logic              mode,
    output logic              pred_c
);

    // Taps not used by either polynomial are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{sreg[9:8], sreg[4:0]};

    // Select the feedback XOR for the active pattern.
    always_comb begin
        pred_c = sreg[PRBS7_TAP_A] ^ sreg[PRBS7_TAP_B];
        if (mode) begin
            pred_c = sreg[PRBS13_TAP_A] ^ sreg[PRBS13_TAP_B]
                   ^ sreg[PRBS13_TAP_C] ^ sreg[PRBS13_TAP_D];
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-7/13 receive checker with lock FSM and BER counters.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned LOSS_WIN    = 64,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             control,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             counters_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] error_count
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WBIT_W  = $clog2(LOSS_WIN + 1);
    localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 1);

    state_e              state_q, state_nxt;
    logic                ctrl_q, ctrl_d;
    logic [SREG_W-1:0]   sreg, sreg_nxt, sreg_shift;
    logic [FILL_W-1:0]   fill_cnt, fill_nxt;
    logic [MATCH_W-1:0]  match_cnt, match_nxt;
    logic [WBIT_W-1:0]   win_bits, win_bits_nxt;
    logic [WERR_W-1:0]   win_errs, win_errs_nxt, win_errs_inc;
    logic                pred, mismatch, mode_chg;
    logic                fill_last, seed_zero, match_last, win_last, loss;
    logic                err_nxt, bit_inc, err_inc;

    assign state = state_q;

    prbs_predict u_predict (
        .sreg   (sreg),
        .mode   (ctrl_q),
        .pred_c (pred)
    );

    // Per-bit decode: comparison result, shifted reference and terminal counts.
    always_comb begin
        mode_chg     = ctrl_q ^ ctrl_d;
        mismatch     = rx_bit ^ pred;
        sreg_shift   = {sreg[SREG_W-2:0], (state_q == ST_LOCKED) ? pred : rx_bit};
        fill_last    = (fill_cnt == seed_len(ctrl_q) - FILL_W'(1));
        seed_zero    = ctrl_q ? (sreg_shift == '0) : (sreg_shift[PRBS7_LEN-1:0] == '0);
        match_last   = (match_cnt == MATCH_W'(LOCK_CNT - 1));
        win_last     = (win_bits == WBIT_W'(LOSS_WIN - 1));
        win_errs_inc = win_errs + WERR_W'(mismatch);
        loss         = (win_errs_inc == WERR_W'(LOSS_THRESH));
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_HUNT;
        else        state_q <= state_nxt;
    end

    // Next-state logic; a pattern change overrides everything, even idle cycles.
    always_comb begin
        state_nxt = state_q;
        if (mode_chg) begin
            state_nxt = ST_HUNT;
        end else if (rx_valid) begin
            case (state_q)
                ST_HUNT:   if (fill_last && !seed_zero) state_nxt = ST_VERIFY;
                ST_VERIFY: begin
                    if (mismatch)        state_nxt = ST_HUNT;
                    else if (match_last) state_nxt = ST_LOCKED;
                end
                ST_LOCKED: if (mismatch && loss) state_nxt = ST_HUNT;
                default:   state_nxt = ST_HUNT;
            endcase
        end
    end

    // Datapath next values: reference shift, fill/match/window counters, events.
    always_comb begin
        sreg_nxt     = sreg;
        fill_nxt     = fill_cnt;
        match_nxt    = match_cnt;
        win_bits_nxt = win_bits;
        win_errs_nxt = win_errs;
        err_nxt      = 1'b0;
        bit_inc      = 1'b0;
        err_inc      = 1'b0;
        if (mode_chg) begin
            fill_nxt     = '0;
            match_nxt    = '0;
            win_bits_nxt = '0;
            win_errs_nxt = '0;
        end else if (rx_valid) begin
            sreg_nxt = sreg_shift;
            case (state_q)
                ST_HUNT: begin
                    fill_nxt     = fill_last ? '0 : fill_cnt + FILL_W'(1);
                    match_nxt    = '0;
                    win_bits_nxt = '0;
                    win_errs_nxt = '0;
                end
                ST_VERIFY: begin
                    fill_nxt     = '0;
                    match_nxt    = (mismatch || match_last) ? '0 : match_cnt + MATCH_W'(1);
                    win_bits_nxt = '0;
                    win_errs_nxt = '0;
                end
                ST_LOCKED: begin
                    err_nxt = mismatch;
                    bit_inc = 1'b1;
                    err_inc = mismatch;
                    if ((mismatch && loss) || win_last) begin
                        win_bits_nxt = '0;
                        win_errs_nxt = '0;
                    end else begin
                        win_bits_nxt = win_bits + WBIT_W'(1);
                        win_errs_nxt = win_errs_inc;
                    end
                end
                default: begin
                    fill_nxt  = '0;
                    match_nxt = '0;
                end
            endcase
        end
    end

    // Datapath registers, registered outputs and saturating BER counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_q      <= 1'b0;
            ctrl_d      <= 1'b0;
            sreg        <= '0;
            fill_cnt    <= '0;
            match_cnt   <= '0;
            win_bits    <= '0;
            win_errs    <= '0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            bit_count   <= '0;
            error_count <= '0;
        end else begin
            ctrl_q    <= control;
            ctrl_d    <= ctrl_q;
            sreg      <= sreg_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            win_bits  <= win_bits_nxt;
            win_errs  <= win_errs_nxt;
            locked    <= (state_nxt == ST_LOCKED);
            err_pulse <= err_nxt;
            if (counters_clr) begin
                bit_count   <= '0;
                error_count <= '0;
            end else begin
                if (bit_inc && (bit_count != '1))   bit_count   <= bit_count + CNT_W'(1);
                if (err_inc && (error_count != '1)) error_count <= error_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed testbench for prbs_checker: lock timing, errors, loss, mode switch, saturation, reset.
module tb_prbs_checker;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        control;
    logic        rx_bit;
    logic        rx_valid;
    logic        counters_clr;

    logic        locked,  err_pulse;
    logic [1:0]  state;
    logic [31:0] bit_count, error_count;

    logic        locked8, err_pulse8;
    logic [1:0]  state8;
    logic [7:0]  bit_count8, error_count8;

    logic [6:0]  g7;
    logic [12:0] g13;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    prbs_checker #(.CNT_W(32), .LOCK_CNT(16), .LOSS_WIN(64), .LOSS_THRESH(8)) dut (
        .clock        (clock),
        .reset        (rst_n),
        .control      (control),
        .rx_bit       (rx_bit),
        .rx_valid     (rx_valid),
        .counters_clr (counters_clr),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .state        (state),
        .bit_count    (bit_count),
        .error_count  (error_count)
    );

    prbs_checker #(.CNT_W(8), .LOCK_CNT(16), .LOSS_WIN(64), .LOSS_THRESH(8)) dut8 (
        .clock        (clock),
        .reset        (rst_n),
        .control      (control),
        .rx_bit       (rx_bit),
        .rx_valid     (rx_valid),
        .counters_clr (counters_clr),
        .locked       (locked8),
        .err_pulse    (err_pulse8),
        .state        (state8),
        .bit_count    (bit_count8),
        .error_count  (error_count8)
    );

    // One clock of stimulus; returns 1 time unit after the sampling edge.
    task automatic drive(input logic b, input logic v, input logic clr);
        rx_bit       = b;
        rx_valid     = v;
        counters_clr = clr;
        @(posedge clock);
        #1;
        rx_valid     = 1'b0;
        counters_clr = 1'b0;
    endtask

    task automatic next7(output logic b);
        b  = g7[6] ^ g7[5];
        g7 = {g7[5:0], b};
    endtask

    task automatic next13(output logic b);
        b   = g13[12] ^ g13[11] ^ g13[10] ^ g13[7];
        g13 = {g13[11:0], b};
    endtask

    task automatic send7(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            next7(b);
            drive(b, 1'b1, 1'b0);
        end
    endtask

    task automatic send13(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            next13(b);
            drive(b, 1'b1, 1'b0);
        end
    endtask

    // Each valid PRBS-7 bit is followed by an idle cycle carrying a junk bit.
    task automatic send7_gappy(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            next7(b);
            drive(b, 1'b1, 1'b0);
            drive(1'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset;
        rst_n        = 1'b0;
        rx_valid     = 1'b0;
        rx_bit       = 1'b0;
        counters_clr = 1'b0;
        control      = 1'b0;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        control      = 1'b0;
        rx_bit       = 1'b0;
        rx_valid     = 1'b0;
        counters_clr = 1'b0;
        #2;
        checks++; if (locked !== 1'b0)    begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err_pulse got=%0b exp=0", err_pulse); end
        checks++; if (state !== 2'd0)     begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (bit_count !== 32'd0 || error_count !== 32'd0)
            begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bit_count, error_count); end
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_idle_state got=%0d exp=0", state); end
    endtask

    task automatic test_lock7;
        do_reset();
        g7 = 7'h7F;
        send7(22);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock7_bit22_locked got=%0b exp=0", locked); end
        checks++; if (state !== 2'd1)  begin failures++; $display("FAIL lock7_bit22_state got=%0d exp=1", state); end
        send7(1);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock7_bit23_locked got=%0b exp=1", locked); end
        checks++; if (state !== 2'd2)  begin failures++; $display("FAIL lock7_bit23_state got=%0d exp=2", state); end
        checks++; if (bit_count !== 32'd0) begin failures++; $display("FAIL lock7_bit23_count got=%0d exp=0", bit_count); end
        send7(1000);
        checks++; if (bit_count !== 32'd1000) begin failures++; $display("FAIL lock7_bits got=%0d exp=1000", bit_count); end
        checks++; if (error_count !== 32'd0)  begin failures++; $display("FAIL lock7_errs got=%0d exp=0", error_count); end
    endtask

    task automatic test_single_error;
        logic b;
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (bit_count !== 32'd0) begin failures++; $display("FAIL clr_bits got=%0d exp=0", bit_count); end
        send7(10);
        next7(b);
        drive(~b, 1'b1, 1'b0);
        checks++; if (err_pulse !== 1'b1)      begin failures++; $display("FAIL single_err_pulse got=%0b exp=1", err_pulse); end
        checks++; if (error_count !== 32'd1)   begin failures++; $display("FAIL single_err_count got=%0d exp=1", error_count); end
        checks++; if (bit_count !== 32'd11)    begin failures++; $display("FAIL single_err_bits got=%0d exp=11", bit_count); end
        checks++; if (locked !== 1'b1)         begin failures++; $display("FAIL single_err_locked got=%0b exp=1", locked); end
        send7(1);
        checks++; if (err_pulse !== 1'b0)      begin failures++; $display("FAIL single_err_pulse_end got=%0b exp=0", err_pulse); end
    endtask

    task automatic test_loss;
        logic b;
        do_reset();
        g7 = 7'h7F;
        send7(23);
        for (int i = 0; i < 7; i++) begin
            next7(b);
            drive(~b, 1'b1, 1'b0);
        end
        checks++; if (locked !== 1'b1 || error_count !== 32'd7)
            begin failures++; $display("FAIL loss_7err got=%0b/%0d exp=1/7", locked, error_count); end
        next7(b);
        drive(~b, 1'b1, 1'b0);
        checks++; if (locked !== 1'b0)       begin failures++; $display("FAIL loss_8err_locked got=%0b exp=0", locked); end
        checks++; if (state !== 2'd0)        begin failures++; $display("FAIL loss_8err_state got=%0d exp=0", state); end
        checks++; if (error_count !== 32'd8) begin failures++; $display("FAIL loss_8err_count got=%0d exp=8", error_count); end
        send7(22);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL relock_22 got=%0b exp=0", locked); end
        send7(1);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL relock_23 got=%0b exp=1", locked); end
    endtask

    task automatic test_mode_switch;
        do_reset();
        g7 = 7'h5A;
        send7(23);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL mode_pre_locked got=%0b exp=1", locked); end
        control = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL mode_edge1_locked got=%0b exp=1", locked); end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (locked !== 1'b0 || state !== 2'd0)
            begin failures++; $display("FAIL mode_edge2 got=%0b/%0d exp=0/0", locked, state); end
        g13 = 13'h1ABC;
        send13(28);
        checks++; if (locked !== 1'b0 || state !== 2'd1)
            begin failures++; $display("FAIL mode13_bit28 got=%0b/%0d exp=0/1", locked, state); end
        send13(1);
        checks++; if (locked !== 1'b1 || state !== 2'd2)
            begin failures++; $display("FAIL mode13_bit29 got=%0b/%0d exp=1/2", locked, state); end
        for (int i = 0; i < 200; i++) drive(1'b0, 1'b1, 1'b0);
        checks++; if (state !== 2'd0 || locked !== 1'b0)
            begin failures++; $display("FAIL zeros_hunt got=%0d/%0b exp=0/0", state, locked); end
    endtask

    task automatic test_saturation;
        logic b;
        do_reset();
        g7 = 7'h7F;
        send7(23);
        send7(300);
        checks++; if (bit_count !== 32'd300) begin failures++; $display("FAIL sat_bits32 got=%0d exp=300", bit_count); end
        checks++; if (bit_count8 !== 8'd255) begin failures++; $display("FAIL sat_bits8 got=%0d exp=255", bit_count8); end
        checks++; if (locked8 !== 1'b1 || state8 !== 2'd2)
            begin failures++; $display("FAIL sat_lock8 got=%0b/%0d exp=1/2", locked8, state8); end
        next7(b);
        drive(~b, 1'b1, 1'b1);
        checks++; if (error_count !== 32'd0 || error_count8 !== 8'd0)
            begin failures++; $display("FAIL clr_vs_err got=%0d/%0d exp=0/0", error_count, error_count8); end
        checks++; if (err_pulse !== 1'b1 || err_pulse8 !== 1'b1)
            begin failures++; $display("FAIL clr_err_pulse got=%0b/%0b exp=1/1", err_pulse, err_pulse8); end
        checks++; if (bit_count8 !== 8'd0) begin failures++; $display("FAIL clr_bits8 got=%0d exp=0", bit_count8); end
        next7(b);
        drive(~b, 1'b1, 1'b0);
        checks++; if (error_count !== 32'd1) begin failures++; $display("FAIL post_clr_err got=%0d exp=1", error_count); end
    endtask

    task automatic test_gaps_reset;
        logic b;
        do_reset();
        g7 = 7'h33;
        send7_gappy(22);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL gap_bit22 got=%0b exp=0", locked); end
        send7_gappy(1);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gap_bit23 got=%0b exp=1", locked); end
        send7_gappy(5);
        checks++; if (bit_count !== 32'd5 || err_pulse !== 1'b0)
            begin failures++; $display("FAIL gap_bits got=%0d/%0b exp=5/0", bit_count, err_pulse); end
        next7(b);
        rx_bit   = b;
        rx_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (locked !== 1'b0 || state !== 2'd0)
            begin failures++; $display("FAIL async_rst_state got=%0b/%0d exp=0/0", locked, state); end
        checks++; if (bit_count !== 32'd0 || error_count !== 32'd0)
            begin failures++; $display("FAIL async_rst_counts got=%0d/%0d exp=0/0", bit_count, error_count); end
        @(posedge clock);
        #1;
        rst_n    = 1'b1;
        rx_valid = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL post_rst_state got=%0d exp=0", state); end
    endtask

    initial begin
        test_reset();
        test_lock7();
        test_single_error();
        test_loss();
        test_mode_switch();
        test_saturation();
        test_gaps_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
